cacheline_adaptor: RTL and testbench



---
 rtl/cacheline_adaptor_pkg.sv | 20 ++
 rtl/cacheline_adaptor_beat_buffer.sv | 40 ++++
 rtl/cacheline_adaptor.sv | 158 +++++++++++++++
 tb/tb_cacheline_adaptor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizes for the cache line <-> burst adaptor.
// The beat index width is derived from the line and beat sizes.
package cacheline_adaptor_pkg;

    localparam int s_offset  = 5;
    localparam int s_line    = 256;
    localparam int s_beat    = 64;
    localparam int num_beats = s_line / s_beat;
    localparam int idx_w     = $clog2(num_beats);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    typedef logic [idx_w-1:0] beat_idx_t;

endpackage

// File: rtl/cacheline_adaptor_beat_buffer.sv
// One cache line of storage, loadable as a whole line or one beat at a time.
// Reads back either the whole line or the beat selected by idx.
module cacheline_adaptor_beat_buffer
    import cacheline_adaptor_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              line_load,
    input  logic [s_line-1:0] line_in,
    input  logic              beat_load,
    input  beat_idx_t         idx,
    input  logic [s_beat-1:0] beat_in,
    output logic [s_beat-1:0] beat_out,
    output logic [s_line-1:0] line_out
);

    logic [s_line-1:0] line_q;
    logic [s_line-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (line_load) begin
            line_d = line_in;
        end else if (beat_load) begin
            line_d[idx*s_beat +: s_beat] = beat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_out = line_q;
    assign beat_out = line_q[idx*s_beat +: s_beat];

endmodule

// File: rtl/cacheline_adaptor.sv
// Turns 256-bit cache line requests into 4-beat 64-bit bursts and back,
// with a per-beat idle timeout that aborts the request with an error.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned timeout = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pmem_addr,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              pmem_error,
    output logic [31:0]       burst_addr,
    output logic              burst_read,
    output logic              burst_write,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int TW = $clog2(timeout + 1);
    localparam beat_idx_t last_beat = beat_idx_t'(num_beats - 1);

    state_t    state_q, state_d;
    logic [31:0] burst_addr_q, burst_addr_d;
    beat_idx_t k_q, k_d;
    logic [TW-1:0] timer_q, timer_d;
    logic resp_q, resp_d;
    logic err_q, err_d;
    logic rd_q, rd_d;
    logic wr_q, wr_d;
    logic rbeat_load;
    logic wline_load;

    logic [s_beat-1:0] rbuf_beat_unused;
    logic [s_line-1:0] wbuf_line_unused;
    logic              addr_low_unused;

    assign addr_low_unused = ^pmem_addr[s_offset-1:0];

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        k_d          = k_q;
        timer_d      = timer_q;
        resp_d       = 1'b0;
        err_d        = 1'b0;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        rbeat_load   = 1'b0;
        wline_load   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    burst_addr_d = {pmem_addr[31:s_offset], {s_offset{1'b0}}};
                    k_d          = '0;
                    timer_d      = '0;
                end
                if (pmem_read && pmem_write) begin
                    state_d = DONE;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (pmem_read) begin
                    state_d = READ;
                    rd_d    = 1'b1;
                end else if (pmem_write) begin
                    state_d    = WRITE;
                    wr_d       = 1'b1;
                    wline_load = 1'b1;
                end
            end
            READ, WRITE: begin
                if (burst_resp) begin
                    rbeat_load = (state_q == READ);
                    k_d        = k_q + 1'b1;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                // k wraps to 0 on the last beat, together with the exit.
                if (burst_resp && k_q == last_beat) begin
                    state_d = DONE;
                    resp_d  = 1'b1;
                end else if (!burst_resp && timer_d == TW'(timeout)) begin
                    state_d = DONE;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    rd_d = (state_q == READ);
                    wr_d = (state_q == WRITE);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_addr_q <= '0;
            k_q          <= '0;
            timer_q      <= '0;
            resp_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            k_q          <= k_d;
            timer_q      <= timer_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    cacheline_adaptor_beat_buffer u_rbuf (
        .clk       (clk),
        .reset     (reset),
        .line_load (1'b0),
        .line_in   ({s_line{1'b0}}),
        .beat_load (rbeat_load),
        .idx       (k_q),
        .beat_in   (burst_rdata),
        .beat_out  (rbuf_beat_unused),
        .line_out  (pmem_rdata)
    );

    cacheline_adaptor_beat_buffer u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .line_load (wline_load),
        .line_in   (pmem_wdata),
        .beat_load (1'b0),
        .idx       (k_q),
        .beat_in   ({s_beat{1'b0}}),
        .beat_out  (burst_wdata),
        .line_out  (wbuf_line_unused)
    );

    assign pmem_resp   = resp_q;
    assign pmem_error  = err_q;
    assign burst_addr  = burst_addr_q;
    assign burst_read  = rd_q;
    assign burst_write = wr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench: the bench plays both cache and burst memory and
// predicts timing, errors and line data from the request/beat rules.
module tb_cacheline_adaptor;

    localparam int TO = 8;

    logic         clk;
    logic         reset;
    logic [31:0]  pmem_addr;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         pmem_error;
    logic [31:0]  burst_addr;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_checks;
    int n_errors;
    logic [255:0] model_rdata;

    cacheline_adaptor #(.timeout(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .pmem_addr   (pmem_addr),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .pmem_error  (pmem_error),
        .burst_addr  (burst_addr),
        .burst_read  (burst_read),
        .burst_write (burst_write),
        .burst_wdata (burst_wdata),
        .burst_rdata (burst_rdata),
        .burst_resp  (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
            burst_resp = 1'($urandom_range(0, 1));
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            check("idle_resp", pmem_resp, 0);
            check("idle_burst", {burst_read, burst_write}, 0);
        end
    endtask

    // kind: 0 read, 1 write, 2 read+write (illegal).
    // nb beats are served (gap[i] idle cycles before beat i), then silence.
    task automatic txn(input int kind, input logic [31:0] addr,
                       input logic [255:0] wl, input logic [255:0] rl,
                       input int g0, input int g1, input int g2,
                       input int g3, input int nb);
        int gap[4];
        int bc[4];
        int last;
        int rc;
        logic err;
        logic [255:0] exp_rd;
        gap = '{g0, g1, g2, g3};
        last = 0;
        for (int i = 0; i < 4; i++) begin
            bc[i] = last + 1 + gap[i];
            if (i < nb) last = bc[i];
        end
        if (kind == 2) begin
            rc = 1;
            err = 1'b1;
        end else if (nb == 4) begin
            rc = last + 1;
            err = 1'b0;
        end else begin
            // TO idle cycles after the last beat, then the response cycle
            rc = last + TO + 1;
            err = 1'b1;
        end
        exp_rd = model_rdata;
        if (kind == 0)
            for (int i = 0; i < nb; i++) exp_rd[64*i +: 64] = rl[64*i +: 64];
        model_rdata = exp_rd;

        @(posedge clk); #1;
        pmem_addr  = addr;
        pmem_read  = (kind != 1);
        pmem_write = (kind != 0);
        pmem_wdata = wl;
        burst_resp = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("req_resp", pmem_resp, 0);
        check("req_burst", {burst_read, burst_write}, 0);

        for (int c = 1; c <= rc; c++) begin
            int b;
            b = -1;
            for (int i = 0; i < nb; i++) if (bc[i] == c) b = i;
            @(posedge clk); #1;
            if (c == rc) burst_resp = 1'($urandom_range(0, 1));
            else burst_resp = (b >= 0);
            if (b >= 0) burst_rdata = rl[64*b +: 64];
            else burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            if (c < rc) begin
                check("burst_read", burst_read, kind == 0);
                check("burst_write", burst_write, kind == 1);
                check("early_resp", pmem_resp, 0);
                if (kind == 1 && b >= 0)
                    check("burst_wdata", burst_wdata, wl[64*b +: 64]);
            end else begin
                check("resp", pmem_resp, 1);
                check("error", pmem_error, err);
                check("rdata", pmem_rdata, exp_rd);
                check("done_burst", {burst_read, burst_write}, 0);
                check("burst_addr", burst_addr, {addr[31:5], 5'b0});
            end
        end
    endtask

    task automatic reset_mid_read(input logic [31:0] addr);
        @(posedge clk); #1;
        pmem_addr  = addr;
        pmem_read  = 1'b1;
        pmem_write = 1'b0;
        burst_resp = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        burst_resp = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("pre_reset_read", burst_read, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        pmem_read = 1'b0;
        @(negedge clk);
        model_rdata = '0;
        check("rst_burst_read", burst_read, 0);
        check("rst_resp", pmem_resp, 0);
        check("rst_rdata", pmem_rdata, model_rdata);
        check("rst_addr", burst_addr, 0);
        idle(2 * TO);
    endtask

    initial begin
        logic [255:0] la;
        logic [255:0] lb;
        n_checks = 0;
        n_errors = 0;
        model_rdata = '0;
        reset = 1'b1;
        pmem_addr = '0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp", pmem_resp, 0);
        check("rst_error", pmem_error, 0);
        check("rst_burst", {burst_read, burst_write}, 0);
        check("rst_addr", burst_addr, 0);
        check("rst_wdata", burst_wdata, 0);
        check("rst_rdata", pmem_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        la = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        txn(0, 32'h0000_1234, rand_line(), la, 0, 0, 0, 0, 4);
        idle(1);
        lb = {{16{4'hd}}, {16{4'hc}}, {16{4'hb}}, {16{4'ha}}};
        txn(1, 32'h0000_5678, lb, rand_line(), 2, 2, 2, 2, 4);
        idle(2);
        txn(0, 32'hdead_beef, rand_line(), rand_line(), 0, 0, 0, 0, 1);
        txn(2, 32'h0000_0040, rand_line(), rand_line(), 0, 0, 0, 0, 4);
        txn(1, 32'h1000_0020, rand_line(), rand_line(), 0, 1, 0, 3, 4);
        txn(0, 32'h2000_0060, rand_line(), rand_line(), 1, 0, 2, 0, 4);
        txn(0, 32'h3000_001f, rand_line(), rand_line(),
            TO - 1, TO - 1, TO - 1, TO - 1, 4);
        txn(1, 32'h3000_0080, rand_line(), rand_line(),
            TO - 1, 0, TO - 1, 0, 4);
        txn(1, 32'h4000_0000, rand_line(), rand_line(), 0, 0, 0, 0, 0);
        txn(0, 32'h4000_0100, rand_line(), rand_line(), 0, 0, 0, 0, 0);
        txn(1, 32'h4000_0200, rand_line(), rand_line(), 1, 1, 1, 0, 3);
        idle(1);
        reset_mid_read(32'h5555_5555);
        txn(0, 32'h6000_0040, rand_line(), rand_line(), 0, 1, 0, 0, 4);

        for (int n = 0; n < 40; n++) begin
            int r;
            int kind;
            int nb;
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 2 : (r < 6) ? 0 : 1;
            nb = ($urandom_range(0, 7) < 2) ? $urandom_range(0, 3) : 4;
            txn(kind, $urandom, rand_line(), rand_line(),
                $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), nb);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
